lz77_stream_encoder: RTL

// - Streaming, parametrised LZ77 encoder. Emits (offset, match_len, char_nxt) tokens.
// - Input arrives one char at a time under valid/ready; no whole-string preload.
// - Each token is held under out_valid/out_ready backpressure.
// - Search-window depth, lookahead depth and symbol width are generic.
// - Streams are delimited by in_last; back-to-back streams are supported.

---
 rtl/lz77_pkg.sv | 25 ++
 rtl/lz77_match_unit.sv | 52 +++++
 rtl/lz77_stream_encoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lz77_pkg.sv
// Shared definitions for the streaming LZ77 encoder.
// Contents: controller state encoding, a constant clog2 helper used to size
// ports and counters, and the default end-of-stream marker character.
package lz77_pkg;

  typedef enum logic [2:0] {
    FILL,
    SEARCH,
    EMIT,
    SHIFT,
    DONE
  } state_e;

  localparam logic [7:0] DEFAULT_END_SYM = 8'h24;

  // Ceiling log2, never less than 1 so that derived widths stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lz77_match_unit.sv
// Combinational match-length evaluator for one search candidate.
// Ports:
//   hist_i      search window, entry 0 = most recently encoded symbol
//   look_i      lookahead buffer, entry 0 = next symbol to encode
//   cand_i      candidate offset into the search window
//   look_cnt_i  number of valid lookahead entries
//   len_o       matched length, capped at min(LOOK_N-1, look_cnt_i)
module lz77_match_unit
  import lz77_pkg::*;
#(
  parameter int unsigned SYM_W    = 8,
  parameter int unsigned SEARCH_N = 9,
  parameter int unsigned LOOK_N   = 8,
  localparam int unsigned OFF_W   = clog2(SEARCH_N),
  localparam int unsigned LEN_W   = clog2(LOOK_N),
  localparam int unsigned LCNT_W  = clog2(LOOK_N + 1)
) (
  input  logic [SEARCH_N-1:0][SYM_W-1:0] hist_i,
  input  logic [LOOK_N-1:0][SYM_W-1:0]   look_i,
  input  logic [OFF_W-1:0]               cand_i,
  input  logic [LCNT_W-1:0]              look_cnt_i,
  output logic [LEN_W-1:0]               len_o
);

  logic             run;
  logic [SYM_W-1:0] src;
  int unsigned      ci;
  int unsigned      cap;

  // Source symbol k walks from history toward the present; once it passes
  // offset 0 it continues into the lookahead itself (overlapping match).
  always_comb begin
    len_o = '0;
    run   = 1'b1;
    src   = '0;
    ci    = 32'(cand_i);
    cap   = (32'(look_cnt_i) < LOOK_N - 1) ? 32'(look_cnt_i) : LOOK_N - 1;
    for (int unsigned k = 0; k < LOOK_N - 1; k++) begin
      if (k <= ci) begin
        src = hist_i[OFF_W'(ci - k)];
      end else begin
        src = look_i[LEN_W'(k - 1 - ci)];
      end
      if (run && (k < cap) && (src == look_i[LEN_W'(k)])) begin
        len_o = LEN_W'(k + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder producing (offset, match_len, char_nxt) tokens.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_valid/in_ready     char handshake; in_data carries the char,
//                         in_last marks the final char of a stream
//   out_valid/out_ready   token handshake; offset, match_len, char_nxt,
//                         out_last are held stable until accepted
//   finish                one-cycle pulse once a stream's last token is retired
module lz77_stream_encoder
  import lz77_pkg::*;
#(
  parameter int unsigned       CHAR_W   = 8,
  parameter int unsigned       SYM_W    = 8,
  parameter int unsigned       SEARCH_N = 9,
  parameter int unsigned       LOOK_N   = 8,
  parameter logic [CHAR_W-1:0] END_SYM  = CHAR_W'(DEFAULT_END_SYM),
  localparam int unsigned      OFF_W    = clog2(SEARCH_N),
  localparam int unsigned      LEN_W    = clog2(LOOK_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [CHAR_W-1:0] char_nxt,
  output logic              out_last,
  output logic              finish
);

  localparam int unsigned HCNT_W = clog2(SEARCH_N + 1);
  localparam int unsigned LCNT_W = clog2(LOOK_N + 1);

  state_e                         state_q, state_d;
  logic [SEARCH_N-1:0][SYM_W-1:0] hist_q, hist_d;
  logic [LOOK_N-1:0][SYM_W-1:0]   look_q, look_d;
  logic [HCNT_W-1:0]              hist_cnt_q, hist_cnt_d;
  logic [LCNT_W-1:0]              look_cnt_q, look_cnt_d;
  logic [LCNT_W-1:0]              shift_cnt_q, shift_cnt_d;
  logic                           last_seen_q, last_seen_d;
  logic [OFF_W-1:0]               cand_q, cand_d;
  logic [OFF_W-1:0]               best_off_q, best_off_d;
  logic [LEN_W-1:0]               best_len_q, best_len_d;
  logic [OFF_W-1:0]               offset_q, offset_d;
  logic [LEN_W-1:0]               match_len_q, match_len_d;
  logic [CHAR_W-1:0]              char_nxt_q, char_nxt_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_last_q, out_last_d;
  logic                           finish_q, finish_d;

  logic [LEN_W-1:0]  cand_len;
  logic [LCNT_W-1:0] consumed;
  logic              accept;

  assign in_ready  = (state_q == FILL) && (look_cnt_q < LCNT_W'(LOOK_N)) && !last_seen_q;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign offset    = offset_q;
  assign match_len = match_len_q;
  assign char_nxt  = char_nxt_q;
  assign out_last  = out_last_q;
  assign finish    = finish_q;

  lz77_match_unit #(
    .SYM_W    (SYM_W),
    .SEARCH_N (SEARCH_N),
    .LOOK_N   (LOOK_N)
  ) u_match (
    .hist_i     (hist_q),
    .look_i     (look_q),
    .cand_i     (cand_q),
    .look_cnt_i (look_cnt_q),
    .len_o      (cand_len)
  );

  // Next-state, datapath and token logic.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    look_d      = look_q;
    hist_cnt_d  = hist_cnt_q;
    look_cnt_d  = look_cnt_q;
    shift_cnt_d = shift_cnt_q;
    last_seen_d = last_seen_q;
    cand_d      = cand_q;
    best_off_d  = best_off_q;
    best_len_d  = best_len_q;
    offset_d    = offset_q;
    match_len_d = match_len_q;
    char_nxt_d  = char_nxt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    finish_d    = 1'b0;
    consumed    = '0;

    case (state_q)
      FILL: begin
        if (accept) begin
          look_d[LEN_W'(look_cnt_q)] = in_data[SYM_W-1:0];
          look_cnt_d                 = look_cnt_q + LCNT_W'(1);
          last_seen_d                = in_last;
        end
        if ((look_cnt_q == LCNT_W'(LOOK_N)) || (last_seen_q && (look_cnt_q != '0))) begin
          state_d    = SEARCH;
          best_len_d = '0;
          best_off_d = '0;
          // Oldest candidate first so that ties keep the largest offset.
          cand_d     = (hist_cnt_q != '0) ? OFF_W'(hist_cnt_q - HCNT_W'(1)) : '0;
        end
      end

      SEARCH: begin
        if ((hist_cnt_q != '0) && (cand_len > best_len_q)) begin
          best_len_d = cand_len;
          best_off_d = cand_q;
        end
        if ((hist_cnt_q == '0) || (cand_q == '0)) begin
          state_d = EMIT;
        end else begin
          cand_d = cand_q - OFF_W'(1);
        end
      end

      EMIT: begin
        if (!out_valid_q) begin
          // A match running to the end of the stream leaves no literal behind it.
          if ((LCNT_W'(best_len_q) == look_cnt_q) && last_seen_q) begin
            char_nxt_d = END_SYM;
            consumed   = LCNT_W'(best_len_q);
          end else begin
            char_nxt_d = CHAR_W'(look_q[best_len_q]);
            consumed   = LCNT_W'(best_len_q) + LCNT_W'(1);
          end
          offset_d    = best_off_q;
          match_len_d = best_len_q;
          out_last_d  = (consumed == look_cnt_q) && last_seen_q;
          shift_cnt_d = consumed;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        hist_d      = {hist_q[SEARCH_N-2:0], look_q[0]};
        look_d      = {SYM_W'(0), look_q[LOOK_N-1:1]};
        look_cnt_d  = look_cnt_q - LCNT_W'(1);
        shift_cnt_d = shift_cnt_q - LCNT_W'(1);
        if (hist_cnt_q != HCNT_W'(SEARCH_N)) begin
          hist_cnt_d = hist_cnt_q + HCNT_W'(1);
        end
        if (shift_cnt_q == LCNT_W'(1)) begin
          state_d  = out_last_q ? DONE : FILL;
          finish_d = out_last_q;
        end
      end

      DONE: begin
        hist_cnt_d  = '0;
        last_seen_d = 1'b0;
        state_d     = FILL;
      end

      default: state_d = FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      hist_q      <= '0;
      look_q      <= '0;
      hist_cnt_q  <= '0;
      look_cnt_q  <= '0;
      shift_cnt_q <= '0;
      last_seen_q <= 1'b0;
      cand_q      <= '0;
      best_off_q  <= '0;
      best_len_q  <= '0;
      offset_q    <= '0;
      match_len_q <= '0;
      char_nxt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      look_q      <= look_d;
      hist_cnt_q  <= hist_cnt_d;
      look_cnt_q  <= look_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      last_seen_q <= last_seen_d;
      cand_q      <= cand_d;
      best_off_q  <= best_off_d;
      best_len_q  <= best_len_d;
      offset_q    <= offset_d;
      match_len_q <= match_len_d;
      char_nxt_q  <= char_nxt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      finish_q    <= finish_d;
    end
  end

endmodule
